// File: rtl/reg_gpr_mp_pkg.sv
// Shared IDs, constants and types for the JX2 general register file.
package reg_gpr_mp_pkg;

    // 6-bit register ID: bit5=0 selects an array register, bit5=1 is special.
    typedef logic [5:0] gpr_id_t;

    // Special (bit5=1) register IDs.
    localparam gpr_id_t JX2_GR_ZZR  = 6'h3F;  // reads as zero
    localparam gpr_id_t JX2_GR_IMM  = 6'h3E;  // reads sign-extended immediate
    localparam gpr_id_t JX2_GR_RSV0 = 6'h20;  // reserved, reads zero
    localparam gpr_id_t JX2_GR_RSV1 = 6'h21;  // reserved, reads zero

    localparam logic [31:0] UV32_00 = 32'h0000_0000;
    localparam logic [31:0] UV32_FF = 32'hFFFF_FFFF;
    localparam logic [63:0] UV64_00 = 64'h0000_0000_0000_0000;

    // Sweep clears the array after reset, then the file runs normally.
    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } gpr_state_e;

    function automatic logic is_array_id(input gpr_id_t id);
        return ~id[5];
    endfunction

endpackage

// File: rtl/reg_gpr_rdport.sv
// One read port: priority forward mux over the lanes plus this port's stall term.
module reg_gpr_rdport
    import reg_gpr_mp_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NFWD  = 2
) (
    input  gpr_id_t                    id_i,
    input  logic [NFWD-1:0][5:0]       fwd_id_i,
    input  logic [NFWD-1:0][WIDTH-1:0] fwd_val_i,
    input  logic [NFWD-1:0]            fwd_ok_i,
    input  logic [WIDTH-1:0]           arr_val_i,
    input  logic                       sb_i,
    input  logic [WIDTH-1:0]           imm_i,
    output logic [WIDTH-1:0]           val_o,
    output logic                       stall_o
);

    logic             hit;
    logic             hit_ok;
    logic [WIDTH-1:0] hit_val;

    // Scan oldest to youngest so the lowest-index (youngest) match wins.
    always_comb begin
        hit     = 1'b0;
        hit_ok  = 1'b0;
        hit_val = '0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_id_i[i] == id_i) begin
                hit     = 1'b1;
                hit_ok  = fwd_ok_i[i];
                hit_val = fwd_val_i[i];
            end
        end
    end

    // Special IDs bypass forwarding entirely and never stall.
    always_comb begin
        val_o   = '0;
        stall_o = 1'b0;
        if (!is_array_id(id_i)) begin
            if (id_i == JX2_GR_IMM)
                val_o = imm_i;
        end else if (hit) begin
            val_o   = hit_val;
            stall_o = ~hit_ok;
        end else begin
            val_o   = arr_val_i;
            stall_o = sb_i;
        end
    end

endmodule

// File: rtl/reg_gpr_mp.sv
// Multi-port GPR file: forwarded reads, oldest-lane commit, pending-write
// scoreboard, and a post-reset sweep that zeroes the array.
module reg_gpr_mp
    import reg_gpr_mp_pkg::*;
#(
    parameter int WIDTH = 64,   // must be at least 33 for the immediate
    parameter int NREGS = 32,
    parameter int NRD   = 3,
    parameter int NFWD  = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       hold,
    input  logic [NRD-1:0][5:0]        regIdRd,
    output logic [NRD-1:0][WIDTH-1:0]  regValRd,
    output logic                       regRdStall,
    input  logic [NFWD-1:0][5:0]       regIdFwd,
    input  logic [NFWD-1:0][WIDTH-1:0] regValFwd,
    input  logic [NFWD-1:0]            regFwdOk,
    input  logic [5:0]                 regIdIss,
    input  logic                       regIssValid,
    input  logic [32:0]                regValImm,
    output logic                       regBusy
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    gpr_state_e       state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [NREGS-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] arr [NREGS];

    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic             cm_en, iss_en;
    logic [WIDTH-1:0] imm_ext;
    logic [NRD-1:0]   port_stall;
    gpr_id_t          cm_id;

    assign cm_id   = regIdFwd[NFWD-1];
    assign cm_en   = (state_q == ST_RUN) && !hold && is_array_id(cm_id) && regFwdOk[NFWD-1];
    assign iss_en  = (state_q == ST_RUN) && !hold && regIssValid && is_array_id(regIdIss);
    assign imm_ext = {{(WIDTH-33){regValImm[32]}}, regValImm};

    // Next state: sweep walks the array writing zeros; run commits and issues.
    // Commit clears before issue sets, so a same-ID pair leaves the bit set.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sb_d    = sb_q;
        we      = 1'b0;
        wa      = cnt_q;
        wd      = '0;
        case (state_q)
            ST_SWEEP: begin
                we    = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(NREGS - 1))
                    state_d = ST_RUN;
            end
            default: begin
                if (cm_en) begin
                    we       = 1'b1;
                    wa       = cm_id[AW-1:0];
                    wd       = regValFwd[NFWD-1];
                    sb_d[wa] = 1'b0;
                end
                if (iss_en)
                    sb_d[regIdIss[AW-1:0]] = 1'b1;
            end
        endcase
    end

    // Control state with asynchronous clear; restarts the sweep from entry 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
            sb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sb_q    <= sb_d;
        end
    end

    // Array storage has no reset; the sweep provides the clear.
    always_ff @(posedge clock) begin
        if (we)
            arr[wa] <= wd;
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        reg_gpr_rdport #(.WIDTH(WIDTH), .NFWD(NFWD)) u_rdport (
            .id_i      (regIdRd[g]),
            .fwd_id_i  (regIdFwd),
            .fwd_val_i (regValFwd),
            .fwd_ok_i  (regFwdOk),
            .arr_val_i (arr[regIdRd[g][AW-1:0]]),
            .sb_i      (sb_q[regIdRd[g][AW-1:0]]),
            .imm_i     (imm_ext),
            .val_o     (regValRd[g]),
            .stall_o   (port_stall[g])
        );
    end

    assign regBusy    = (state_q == ST_SWEEP);
    assign regRdStall = regBusy | (|port_stall);

endmodule

// File: doc/reg_gpr_mp.md
# reg_gpr_mp

Parametrised multi-port general register file for the JX2 pipeline. It provides NRD combinational read ports and NFWD-stage forwarding with per-lane value-ready flags, and commits from the oldest forwarding lane. A pending-write scoreboard raises a stall when a source register's value is not yet available, and a post-reset clear sweep zeroes the array. It sits between decode (read IDs, issue marks) and the EX/WB stages (forward/commit).

## Interface
Parameters:
- WIDTH, 64: register data width.
- NREGS, 32: array registers; IDs 0..NREGS-1 (power of two, at most 32).
- NRD, 3: read ports.
- NFWD, 2: forwarding lanes. Lane 0 is the youngest and has highest priority. Lane NFWD-1 is the commit lane.

Ports:
- clock, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-low reset.
- hold, in, 1: pipeline hold. Blocks commit and issue; does not block the sweep.
- regIdRd, in, NRD*6: read register IDs.
- regValRd, out, NRD*WIDTH: read values.
- regRdStall, out, 1: at least one read cannot be satisfied this cycle.
- regIdFwd, in, NFWD*6: forwarding lane destination IDs.
- regValFwd, in, NFWD*WIDTH: forwarding lane values.
- regFwdOk, in, NFWD: the lane value is final.
- regIdIss, in, 6: destination of a long-latency op being issued.
- regIssValid, in, 1: issue strobe.
- regValImm, in, 33: decode immediate, with bit 32 as the sign.
- regBusy, out, 1: clear sweep in progress.

## Operation
- ID space: bit5=0 selects an array register. JX2_GR_ZZR reads 0. JX2_GR_IMM reads sign-extended regValImm. Any other bit5=1 ID reads 0 and never stalls.
- Read path (per port, combinational):
  - ZZR and IMM are never forwarded.
  - Otherwise the lowest-index lane with a matching ID supplies the value.
  - If that lane's regFwdOk=0, regRdStall=1.
  - If no lane matches and the scoreboard bit is set, regRdStall=1.
  - If no lane matches and the bit is clear, the array value is returned.
- Commit: on a clock edge with hold=0 and regBusy=0, if lane NFWD-1's ID has bit5=0 and regFwdOk[NFWD-1]=1, write its value to the array and clear that scoreboard bit.
- Issue: on a clock edge with hold=0, regBusy=0 and regIssValid=1 with bit5=0, set the scoreboard bit.
- Issue and commit to the same ID in the same cycle: the bit ends set, and the array is still written.
- A commit with regFwdOk=0 or a bit5=1 ID writes nothing and leaves the scoreboard unchanged.
- States are SWEEP and RUN.
  - Reset enters SWEEP with counter 0.
  - SWEEP writes 0 to array[counter] each cycle. After writing entry NREGS-1 it moves to RUN.
- Reset mid-operation: the scoreboard clears immediately, the sweep restarts at entry 0, and in-flight commits are lost.

## Timing
- Reset values: regBusy=1; regRdStall=1 (forced while busy); scoreboard=0; regValRd undefined while busy.
- Sweep duration is NREGS cycles. regBusy falls on the edge that writes entry NREGS-1. The first RUN cycle reads all zeros.
- Read latency is 0 cycles (combinational from IDs, lanes, array and scoreboard).
- A commit is visible in the array on the next cycle. In the commit cycle itself, the value is covered by the forwarding lane.
- An issued register stalls readers from the next cycle until its commit edge.
- regRdStall has no registered path. Decode holds its IDs stable while the stall is high.

## Structure
- Shared package holds:
  - JX2_GR_* IDs: ZZR, IMM, and reserved bit5=1 IDs.
  - UV32_00/UV32_FF/UV64_00 constants.
  - The 6-bit register-ID typedef.
- One sub-module, reg_gpr_rdport: one read port's priority forward mux plus stall term. It is instantiated NRD times in a generate loop.
- Top level holds:
  - the array (no reset; cleared by the sweep);
  - the NREGS-bit scoreboard;
  - the sweep counter and FSM.

## Test plan
- Reset, then idle NREGS=32 cycles:
  - regBusy is high for exactly 32 cycles;
  - regRdStall is high throughout;
  - then reading R5 returns 0 with no stall.
- Commit R3=0x1122334455667788 on lane 1:
  - in the same cycle, a read of R3 returns it through the forward path;
  - the next cycle it returns the array value, identical.
- Lane 0 holds R7=0xAA with Ok=1 while lane 1 holds R7=0xBB: a read of R7 returns 0xAA.
- Issue R9, then read R9 for 3 cycles:
  - regRdStall is high in each cycle;
  - commit R9=0x42 with Ok=1;
  - the next cycle the read returns 0x42 with no stall.
- Read with a ZZR ID:
  - returns 0 and does not stall, even when lane 0 ID equals ZZR with Ok=0.
  - IMM with regValImm=0x1_8000_0000 returns 0xFFFFFFFF80000000.
- Hold and reset:
  - hold=1 with a valid commit of R2=0x55: R2 is unchanged.
  - Assert reset mid-sweep at count 10: the sweep restarts at 0, regBusy stays high for a full 32 cycles after release, and the scoreboard is clear.
